// File: rtl/transmision_dac_multicanal_if.sv
// Frame handshake between the sample generator and the DAC serial transmitter.
// Signals:
//   sample_data   DATA_W*CHANNELS  frame; channel k at [k*DATA_W +: DATA_W]
//   sample_valid  1                producer has a frame on sample_data
//   sample_ready  1                transmitter can take a frame this cycle
// Modports: master = sample producer, slave = transmitter.
interface transmision_dac_multicanal_if #(
    parameter int DATA_W   = 24,
    parameter int CHANNELS = 2
);
    logic [DATA_W*CHANNELS-1:0] sample_data;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (output sample_data, output sample_valid, input  sample_ready);
    modport slave  (input  sample_data, input  sample_valid, output sample_ready);
endinterface

// File: rtl/transmision_dac_multicanal.sv
// Multichannel serial DAC transmitter. Takes one frame of CHANNELS samples over
// the smp handshake and shifts it out MSB-first, channel 0 first, with its own
// bit clock, channel select and frame sync. A one-frame holding buffer keeps
// back-to-back frames gap-free; UNDERRUN_MODE picks stop / zero frame / repeat
// when no new frame is available at a frame boundary.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low
//   smp         frame handshake (slave side)
//   bclk        bit clock; DAC samples data_out on its rising edge
//   data_out    serial data, changes only on bclk falling boundaries
//   chan_sel    channel index of the bit on data_out
//   frame_sync  high for the first bit period of every frame
//   underrun    1-clk pulse when a boundary finds no new frame (modes 1, 2)
module transmision_dac_multicanal #(
    parameter int  DATA_W        = 24,
    parameter int  CHANNELS      = 2,
    parameter int  BCLK_DIV      = 2,
    parameter int  UNDERRUN_MODE = 0,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    transmision_dac_multicanal_if.slave smp,
    output logic                       bclk,
    output logic                       data_out,
    output logic [CH_W-1:0]            chan_sel,
    output logic                       frame_sync,
    output logic                       underrun
);
    localparam int SER_W = DATA_W * CHANNELS;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Frames are stored in transmit order: channel 0 in the top DATA_W bits,
    // so the shifter only ever looks at its MSB.
    function automatic logic [SER_W-1:0] to_serial(input logic [SER_W-1:0] f);
        logic [SER_W-1:0] s;
        for (int k = 0; k < CHANNELS; k++) begin
            s[(CHANNELS-1-k)*DATA_W +: DATA_W] = f[k*DATA_W +: DATA_W];
        end
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [SER_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             arm_q, arm_d;
    logic [SER_W-1:0] shift_q, shift_d;
    logic [SER_W-1:0] last_q, last_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic             fsync_q, fsync_d;
    logic             underrun_q, underrun_d;

    logic             accept;
    logic [SER_W-1:0] in_ser;

    assign accept = smp.sample_valid && !hold_full_q;
    assign in_ser = to_serial(smp.sample_data);

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        // arm delays the IDLE start by one cycle: first bit lands 2 clk after acceptance.
        arm_d       = hold_full_q;
        shift_d     = shift_q;
        last_d      = last_q;
        div_d       = div_q;
        bclk_d      = bclk_q;
        bit_d       = bit_q;
        chan_d      = chan_q;
        fsync_d     = fsync_q;
        underrun_d  = 1'b0;

        if (accept) begin
            hold_d      = in_ser;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q && arm_q) begin
                    state_d     = SHIFT;
                    shift_d     = hold_q;
                    last_d      = hold_q;
                    hold_full_d = 1'b0;
                    div_d       = '0;
                    bclk_d      = 1'b0;
                    bit_d       = '0;
                    chan_d      = '0;
                    fsync_d     = 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_W'(BCLK_DIV - 1)) begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    // bclk falling edge is the bit boundary.
                    if (bclk_q) begin
                        fsync_d = 1'b0;
                        shift_d = shift_q << 1;
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            bit_d = '0;
                            if (chan_q == CH_W'(CHANNELS - 1)) begin
                                chan_d  = '0;
                                fsync_d = 1'b1;
                                if (hold_full_q) begin
                                    shift_d     = hold_q;
                                    last_d      = hold_q;
                                    hold_full_d = 1'b0;
                                end else if (accept) begin
                                    // Bypass: the frame arriving on the boundary goes straight out.
                                    shift_d     = in_ser;
                                    last_d      = in_ser;
                                    hold_d      = hold_q;
                                    hold_full_d = 1'b0;
                                end else begin
                                    case (UNDERRUN_MODE)
                                        1: begin
                                            shift_d    = '0;
                                            underrun_d = 1'b1;
                                        end
                                        2: begin
                                            shift_d    = last_q;
                                            underrun_d = 1'b1;
                                        end
                                        default: begin
                                            state_d = IDLE;
                                            shift_d = '0;
                                            fsync_d = 1'b0;
                                        end
                                    endcase
                                end
                            end else begin
                                chan_d = chan_q + CH_W'(1);
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            // NOTE: the holding buffer and last-frame copy are cleared as well, so a frame dropped by reset can never be replayed.
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            arm_q       <= 1'b0;
            shift_q     <= '0;
            last_q      <= '0;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_q       <= '0;
            chan_q      <= '0;
            fsync_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            arm_q       <= arm_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_q       <= bit_d;
            chan_q      <= chan_d;
            fsync_q     <= fsync_d;
            underrun_q  <= underrun_d;
        end
    end

    assign smp.sample_ready = !hold_full_q;
    assign bclk             = bclk_q;
    assign data_out         = (state_q == SHIFT) && shift_q[SER_W-1];
    assign chan_sel         = chan_q;
    assign frame_sync       = fsync_q;
    assign underrun         = underrun_q;
endmodule

// File: tb/tb_transmision_dac_multicanal.sv
// Directed bench for transmision_dac_multicanal with default DATA_W/CHANNELS/BCLK_DIV.
// Three instances cover UNDERRUN_MODE 0, 1 and 2; sel picks which one is driven and observed.
module tb_transmision_dac_multicanal;
    localparam int DW = 24;
    localparam int CH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] tb_data;
    logic        tb_valid;
    logic [1:0]  sel;

    always #5 clk = ~clk;

    transmision_dac_multicanal_if #(.DATA_W(DW), .CHANNELS(CH)) if0 ();
    transmision_dac_multicanal_if #(.DATA_W(DW), .CHANNELS(CH)) if1 ();
    transmision_dac_multicanal_if #(.DATA_W(DW), .CHANNELS(CH)) if2 ();

    assign if0.sample_data  = tb_data;
    assign if1.sample_data  = tb_data;
    assign if2.sample_data  = tb_data;
    assign if0.sample_valid = tb_valid && (sel == 2'd0);
    assign if1.sample_valid = tb_valid && (sel == 2'd1);
    assign if2.sample_valid = tb_valid && (sel == 2'd2);

    logic [2:0] bclk_w, data_w, chan_w, fs_w, und_w, rdy_w;

    assign rdy_w = {if2.sample_ready, if1.sample_ready, if0.sample_ready};

    transmision_dac_multicanal #(.UNDERRUN_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .smp(if0), .bclk(bclk_w[0]), .data_out(data_w[0]),
        .chan_sel(chan_w[0:0]), .frame_sync(fs_w[0]), .underrun(und_w[0]));
    transmision_dac_multicanal #(.UNDERRUN_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .smp(if1), .bclk(bclk_w[1]), .data_out(data_w[1]),
        .chan_sel(chan_w[1:1]), .frame_sync(fs_w[1]), .underrun(und_w[1]));
    transmision_dac_multicanal #(.UNDERRUN_MODE(2)) dut2 (
        .clk(clk), .reset(reset), .smp(if2), .bclk(bclk_w[2]), .data_out(data_w[2]),
        .chan_sel(chan_w[2:2]), .frame_sync(fs_w[2]), .underrun(und_w[2]));

    logic o_bclk, o_data, o_chan, o_fs, o_und, o_rdy;
    assign o_bclk = bclk_w[sel];
    assign o_data = data_w[sel];
    assign o_chan = chan_w[sel];
    assign o_fs   = fs_w[sel];
    assign o_und  = und_w[sel];
    assign o_rdy  = rdy_w[sel];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_acc;
    int n_rise, first_rise, last_rise, gaps, fs_rises, und_cnt;
    logic prev_bclk, prev_fs;
    logic cap_bits[$], cap_chan[$], cap_fs[$];
    logic exp_bits[$], exp_chan[$], exp_fs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk, then observe 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_bclk && !prev_bclk) begin
            cap_bits.push_back(o_data);
            cap_chan.push_back(o_chan);
            cap_fs.push_back(o_fs);
            if (n_rise == 0) first_rise = cyc;
            else if (cyc - last_rise != 4) gaps++;
            last_rise = cyc;
            n_rise++;
        end
        if (o_fs && !prev_fs) fs_rises++;
        if (o_und) und_cnt++;
        prev_bclk = o_bclk;
        prev_fs   = o_fs;
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic clear_cap();
        cap_bits.delete(); cap_chan.delete(); cap_fs.delete();
        exp_bits.delete(); exp_chan.delete(); exp_fs.delete();
        n_rise = 0; first_rise = 0; last_rise = 0; gaps = 0; fs_rises = 0; und_cnt = 0;
        prev_bclk = o_bclk;
        prev_fs   = o_fs;
    endtask

    // Reference serialisation: channel 0 first, each sample MSB first.
    task automatic push_frame(input logic [47:0] f);
        for (int c = 0; c < CH; c++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                exp_bits.push_back(f[c*DW + b]);
                exp_chan.push_back(c[0]);
                exp_fs.push_back(c == 0 && b == DW - 1);
            end
        end
    endtask

    task automatic compare_stream(input string tag, input int n);
        int mism = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= cap_bits.size() || i >= exp_bits.size()) mism++;
            else if (cap_bits[i] !== exp_bits[i] || cap_chan[i] !== exp_chan[i] ||
                     cap_fs[i] !== exp_fs[i]) mism++;
        end
        check(tag, 32'(mism), 32'd0);
    endtask

    // Holds tb_valid high until accepted; waits = cycles spent with ready low.
    task automatic offer(input logic [47:0] f, output logic ok, output int waits);
        logic rdy;
        ok = 1'b0;
        waits = 0;
        tb_data  = f;
        tb_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            rdy = o_rdy;
            tick();
            if (rdy) ok = 1'b1;
            else waits++;
        end
        t_acc = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   w;
        reset    = 1'b0;
        tb_valid = 1'b1;
        tb_data  = 48'hDEAD_BEEF_CAFE;
        sel      = 2'd0;
        #1;
        clear_cap();

        // Reset held with valid high: nothing moves, all outputs idle, ready high.
        repeat (6) tick();
        check("rst_no_bclk", 32'(n_rise), 32'd0);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check("rst_outputs", 32'({o_bclk, o_data, o_chan, o_fs, o_und, o_rdy}), 32'(6'b000001));
        end
        sel      = 2'd0;
        tb_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("ready_after_release", 32'(o_rdy), 32'd1);

        // Mode 0, single frame.
        clear_cap();
        push_frame({24'h800000, 24'd101});
        offer({24'h800000, 24'd101}, ok, w);
        tb_valid = 1'b0;
        check("single_accept", 32'(ok), 32'd1);
        check("single_ready_low", 32'(o_rdy), 32'd0);
        tick();
        check("single_fs_not_yet", 32'(o_fs), 32'd0);
        tick();
        check("single_fs_start", 32'(o_fs), 32'd1);
        check("single_ready_back", 32'(o_rdy), 32'd1);
        run_until(t_acc + 230);
        check("single_nbits", 32'(n_rise), 32'd48);
        check("single_first_rise", 32'(first_rise - t_acc), 32'd4);
        check("single_last_rise", 32'(last_rise - t_acc), 32'd192);
        check("single_fs_pulses", 32'(fs_rises), 32'd1);
        check("single_underrun", 32'(und_cnt), 32'd0);
        check("single_idle_out", 32'({o_bclk, o_data, o_fs}), 32'd0);
        compare_stream("single_stream", 48);

        // Back-to-back A, B, C with valid held high.
        clear_cap();
        push_frame({24'hA5A5A5, 24'h0F0F0F});
        push_frame({24'h000001, 24'hFFFFFE});
        push_frame({24'h5A5A5A, 24'hC3C3C3});
        offer({24'hA5A5A5, 24'h0F0F0F}, ok, w);
        check("b2b_a_accept", 32'(ok), 32'd1);
        check("b2b_ready_low", 32'(o_rdy), 32'd0);
        offer({24'h000001, 24'hFFFFFE}, ok, w);
        check("b2b_b_wait", 32'(w), 32'd2);
        offer({24'h5A5A5A, 24'hC3C3C3}, ok, w);
        tb_valid = 1'b0;
        check("b2b_c_wait", 32'(w), 32'd191);
        run_until(cyc + 600);
        check("b2b_nbits", 32'(n_rise), 32'd144);
        check("b2b_gaps", 32'(gaps), 32'd0);
        check("b2b_fs_pulses", 32'(fs_rises), 32'd3);
        check("b2b_underrun", 32'(und_cnt), 32'd0);
        compare_stream("b2b_stream", 144);

        // Mode 1: zero frames after a single real frame.
        do_reset();
        sel = 2'd1;
        #1;
        clear_cap();
        push_frame({24'h00ABCD, 24'h765432});
        push_frame(48'd0);
        offer({24'h00ABCD, 24'h765432}, ok, w);
        tb_valid = 1'b0;
        run_until(t_acc + 390);
        check("m1_nbits", 32'(n_rise), 32'd97);
        check("m1_gaps", 32'(gaps), 32'd0);
        check("m1_underrun", 32'(und_cnt), 32'd2);
        compare_stream("m1_stream", 96);

        // Mode 2: the last frame is repeated.
        do_reset();
        sel = 2'd2;
        #1;
        clear_cap();
        push_frame({24'h800001, 24'h7FFFFE});
        push_frame({24'h800001, 24'h7FFFFE});
        offer({24'h800001, 24'h7FFFFE}, ok, w);
        tb_valid = 1'b0;
        run_until(t_acc + 390);
        check("m2_nbits", 32'(n_rise), 32'd97);
        check("m2_underrun", 32'(und_cnt), 32'd2);
        compare_stream("m2_stream", 96);

        // Bypass: second frame offered exactly on the boundary edge.
        do_reset();
        sel = 2'd0;
        #1;
        clear_cap();
        push_frame({24'h13579B, 24'h2468AC});
        push_frame({24'hFEDCBA, 24'h000F00});
        offer({24'h13579B, 24'h2468AC}, ok, w);
        tb_valid = 1'b0;
        run_until(t_acc + 193);
        tb_data  = {24'hFEDCBA, 24'h000F00};
        tb_valid = 1'b1;
        check("byp_ready_pre", 32'(o_rdy), 32'd1);
        tick();
        tb_valid = 1'b0;
        check("byp_hold_empty", 32'(o_rdy), 32'd1);
        check("byp_fs_load", 32'(o_fs), 32'd1);
        run_until(t_acc + 400);
        check("byp_nbits", 32'(n_rise), 32'd96);
        check("byp_gaps", 32'(gaps), 32'd0);
        check("byp_underrun", 32'(und_cnt), 32'd0);
        check("byp_fs_pulses", 32'(fs_rises), 32'd2);
        compare_stream("byp_stream", 96);

        // Reset in the middle of ch0 bit 10 with a second frame waiting in hold.
        do_reset();
        clear_cap();
        offer({24'h000000, 24'hFFFFFF}, ok, w);
        offer({24'hAAAAAA, 24'h555555}, ok, w);
        tb_valid = 1'b0;
        t_acc = t_acc - 3;
        run_until(t_acc + 44);
        check("mid_bit10_seen", 32'(n_rise), 32'd11);
        check("mid_pre_reset", 32'({o_bclk, o_data, o_rdy}), 32'(3'b110));
        reset = 1'b0;
        #1;
        check("mid_async_reset", 32'({o_bclk, o_data, o_chan, o_fs, o_und, o_rdy}), 32'(6'b000001));
        tick();
        tick();
        reset = 1'b1;
        clear_cap();
        run_until(cyc + 20);
        check("mid_hold_cleared", 32'(n_rise), 32'd0);
        push_frame({24'h00F00D, 24'd301});
        offer({24'h00F00D, 24'd301}, ok, w);
        tb_valid = 1'b0;
        run_until(t_acc + 230);
        check("post_nbits", 32'(n_rise), 32'd48);
        check("post_first_rise", 32'(first_rise - t_acc), 32'd4);
        compare_stream("post_stream", 48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
